// File: rtl/audio_pkg.sv
`default_nettype none
// ============================================================================
// Module : audio_pkg
// Brief  : Shared audio-path types, frame geometry and I2S slot helper.
// Rev    : 1.0  initial release
// ============================================================================
package audio_pkg;

    localparam int DEFAULT_SAMPLE_W = 16;
    localparam int FRAME_BITS       = 2 * DEFAULT_SAMPLE_W;

    typedef logic signed [DEFAULT_SAMPLE_W-1:0] sample_t;
    typedef logic [$clog2(FRAME_BITS)-1:0]      slot_t;

    // Sample bit carried by a nonzero slot; the one-bit I2S delay shifts
    // each channel's MSB into the slot after the lrclk change.
    function automatic int unsigned slot_bit_idx(input int unsigned slot,
                                                 input int unsigned sample_w);
        return (slot <= sample_w) ? (sample_w - slot) : (2 * sample_w - slot);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bclk_gen.sv
`default_nettype none
// ============================================================================
// Module : bclk_gen
// Brief  : Bit-clock divider producing bclk plus single-cycle edge strobes.
// Rev    : 1.0  initial release
// ============================================================================
module bclk_gen #(
    parameter int BCLK_DIV = 4
) (
    input  logic clock,
    input  logic reset,
    output logic bclk,
    output logic fall_evt,
    output logic rise_evt
);

    localparam int               CNT_W    = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BCLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             bclk_q;
    logic             bclk_d;
    logic             wrap;

    always_comb begin
        wrap   = (cnt_q == CNT_LAST);
        cnt_d  = wrap ? '0 : cnt_q + CNT_W'(1);
        bclk_d = wrap ? ~bclk_q : bclk_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q  <= '0;
            bclk_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            bclk_q <= bclk_d;
        end
    end

    // Strobes are asserted in the cycle whose closing edge moves bclk.
    assign bclk     = bclk_q;
    assign fall_evt = wrap && bclk_q;
    assign rise_evt = wrap && !bclk_q;

endmodule
`default_nettype wire

// File: rtl/i2s_dac_serializer.sv
`default_nettype none
// ============================================================================
// Module : i2s_dac_serializer
// Brief  : One-entry sample buffer feeding a stereo-duplicated I2S DAC link,
//          with a per-frame sample_tick for upstream pacing.
// Option : UNDERRUN_CNT_EN adds a saturating 16-bit underrun_count output.
// Rev    : 1.0  initial release
// ============================================================================
module i2s_dac_serializer
    import audio_pkg::*;
#(
    parameter int SAMPLE_W = DEFAULT_SAMPLE_W,
    parameter int BCLK_DIV = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [SAMPLE_W-1:0] in_sample,
    input  logic                in_valid,
    output logic                in_ready,
    output logic                sample_tick,
    output logic                bclk,
    output logic                lrclk,
    output logic                dacdat
`ifdef UNDERRUN_CNT_EN
    ,
    output logic [15:0]         underrun_count
`endif
);

    localparam int              FRAME_N   = 2 * SAMPLE_W;
    localparam int              SLOT_W    = $clog2(FRAME_N);
    localparam int              IDX_W     = $clog2(SAMPLE_W);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(FRAME_N - 1);

    logic                fall_evt;
    logic                rise_evt;

    logic [SLOT_W-1:0]   k_q;
    logic [SLOT_W-1:0]   k_d;
    logic [SAMPLE_W-1:0] pending_q;
    logic [SAMPLE_W-1:0] pending_d;
    logic                pending_full_q;
    logic                pending_full_d;
    logic [SAMPLE_W-1:0] frame_q;
    logic [SAMPLE_W-1:0] frame_d;
    logic                lrclk_q;
    logic                lrclk_d;
    logic                dacdat_q;
    logic                dacdat_d;
    logic                tick_q;
    logic                tick_d;

    logic [SLOT_W-1:0]   k_next;
    logic [IDX_W-1:0]    bit_idx;
    logic                load;
    logic                take;

    bclk_gen #(
        .BCLK_DIV (BCLK_DIV)
    ) u_bclk_gen (
        .clock    (clock),
        .reset    (reset),
        .bclk     (bclk),
        .fall_evt (fall_evt),
        .rise_evt (rise_evt)
    );

    always_comb begin
        k_next  = (k_q == SLOT_LAST) ? '0 : k_q + SLOT_W'(1);
        bit_idx = IDX_W'(slot_bit_idx(32'(k_next), $unsigned(SAMPLE_W)));
        load    = fall_evt && (k_next == '0);
        take    = in_valid && !pending_full_q;
    end

    // Load decisions use the pre-cycle buffer state; a same-cycle transfer
    // only fills the buffer for the following frame.
    always_comb begin
        pending_d      = pending_q;
        pending_full_d = pending_full_q;
        frame_d        = frame_q;
        if (load && pending_full_q) begin
            frame_d        = pending_q;
            pending_full_d = 1'b0;
        end
        if (take) begin
            pending_d      = in_sample;
            pending_full_d = 1'b1;
        end
    end

    always_comb begin
        k_d      = k_q;
        lrclk_d  = lrclk_q;
        dacdat_d = dacdat_q;
        tick_d   = load;
        if (fall_evt) begin
            k_d      = k_next;
            lrclk_d  = (k_next >= SLOT_W'(SAMPLE_W));
            dacdat_d = (k_next == '0) ? frame_q[0] : frame_q[bit_idx];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            k_q            <= SLOT_LAST;
            pending_q      <= '0;
            pending_full_q <= 1'b0;
            frame_q        <= '0;
            lrclk_q        <= 1'b0;
            dacdat_q       <= 1'b0;
            tick_q         <= 1'b0;
        end else begin
            k_q            <= k_d;
            pending_q      <= pending_d;
            pending_full_q <= pending_full_d;
            frame_q        <= frame_d;
            lrclk_q        <= lrclk_d;
            dacdat_q       <= dacdat_d;
            tick_q         <= tick_d;
        end
    end

    assign in_ready    = !pending_full_q;
    assign sample_tick = tick_q;
    assign lrclk       = lrclk_q;
    assign dacdat      = dacdat_q;

`ifdef UNDERRUN_CNT_EN
    logic [15:0] underrun_q;
    logic [15:0] underrun_d;

    always_comb begin
        underrun_d = underrun_q;
        if (load && !pending_full_q && (underrun_q != 16'hFFFF)) begin
            underrun_d = underrun_q + 16'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            underrun_q <= '0;
        end else begin
            underrun_q <= underrun_d;
        end
    end

    assign underrun_count = underrun_q;
`endif

    // Serial outputs must hold steady across the bclk rising edge.
    stable_on_rise: assert property (@(posedge clock) disable iff (reset)
        rise_evt |-> ((lrclk_d == lrclk_q) && (dacdat_d == dacdat_q)));

endmodule
`default_nettype wire

// File: tb/tb_i2s_dac_serializer.sv
`default_nettype none
// ============================================================================
// Module : tb_i2s_dac_serializer
// Brief  : Randomized scoreboard bench: frame-level reference model feeds an
//          expected-frame queue, an I2S receiver monitor pops and compares.
// Rev    : 1.0  initial release
// ============================================================================
module tb_i2s_dac_serializer;

    localparam int SW        = 16;
    localparam int DIV       = 4;
    localparam int FALL_PER  = 2 * DIV;
    localparam int FRAME_CLK = 2 * SW * FALL_PER;
    localparam int LOAD_PH   = FALL_PER;

    logic          clock     = 1'b0;
    logic          reset     = 1'b1;
    logic [SW-1:0] in_sample = '0;
    logic          in_valid  = 1'b0;
    logic          in_ready;
    logic          sample_tick;
    logic          bclk;
    logic          lrclk;
    logic          dacdat;
`ifdef UNDERRUN_CNT_EN
    logic [15:0]   underrun_count;
`endif

    i2s_dac_serializer #(
        .SAMPLE_W (SW),
        .BCLK_DIV (DIV)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .in_sample   (in_sample),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .sample_tick (sample_tick),
        .bclk        (bclk),
        .lrclk       (lrclk),
        .dacdat      (dacdat)
`ifdef UNDERRUN_CNT_EN
        ,
        .underrun_count (underrun_count)
`endif
    );

    always #5 clock = ~clock;

    int            vectors = 0;
    int            errors  = 0;
    int            frames  = 0;

    // Reference model state: clocks since reset release, one-deep buffer,
    // current frame sample and the queue of frames the link must carry.
    int            cyc       = 0;
    logic [SW-1:0] pend_q[$];
    logic [SW-1:0] exp_q[$];
    logic [SW-1:0] frame_s   = '0;
    int unsigned   underruns = 0;
    bit            took_last = 1'b0;
    bit            was_full;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int slot_of(input int c);
        int f;
        f = c / FALL_PER;
        return (f == 0) ? -1 : (f - 1) % (2 * SW);
    endfunction

    always @(posedge clock) begin
        if (reset) begin
            cyc       = 0;
            pend_q.delete();
            exp_q.delete();
            frame_s   = '0;
            underruns = 0;
            took_last = 1'b0;
        end else begin
            was_full  = (pend_q.size() != 0);
            cyc++;
            took_last = in_valid && !was_full;
            if ((cyc % FRAME_CLK) == LOAD_PH) begin
                if (was_full) frame_s = pend_q.pop_front();
                else if (underruns != 32'hFFFF) underruns++;
                exp_q.push_back(frame_s);
            end
            if (took_last) pend_q.push_back(in_sample);
        end
    end

    // Cycle-level checks of clocking, framing and handshake.
    always @(negedge clock) begin
        int s;
        s = slot_of(cyc);
        chk("bclk", 32'(bclk), 32'((cyc / DIV) % 2));
        chk("lrclk", 32'(lrclk), (s >= SW) ? 32'd1 : 32'd0);
        chk("in_ready", 32'(in_ready), 32'(pend_q.size() == 0));
        chk("sample_tick", 32'(sample_tick), 32'((cyc % FRAME_CLK) == LOAD_PH));
        if (s < 0) chk("dacdat_idle", 32'(dacdat), 32'd0);
`ifdef UNDERRUN_CNT_EN
        chk("underrun_count", 32'(underrun_count), underruns);
`endif
    end

    // I2S receiver: bits taken on bclk rise; an lrclk change marks the
    // rise carrying the previous channel's LSB.
    logic [SW-1:0] sh;
    logic [SW-1:0] left_w;
    logic          prev_bclk = 1'b1;
    logic          prev_lr   = 1'b0;
    bit            have_left = 1'b0;
    logic [SW-1:0] e;

    always @(negedge clock) begin
        if (reset) begin
            sh        = '0;
            prev_bclk = 1'b1;
            prev_lr   = 1'b0;
            have_left = 1'b0;
        end else begin
            if (bclk && !prev_bclk) begin
                sh = {sh[SW-2:0], dacdat};
                if (lrclk != prev_lr) begin
                    if (lrclk) begin
                        left_w    = sh;
                        have_left = 1'b1;
                    end else if (have_left) begin
                        chk("frame_expected", 32'(exp_q.size() != 0), 32'd1);
                        if (exp_q.size() != 0) begin
                            e = exp_q.pop_front();
                            chk("left_word", 32'(left_w), 32'(e));
                            chk("right_word", 32'(sh), 32'(e));
                            frames++;
                        end
                        have_left = 1'b0;
                    end
                end
                prev_lr = lrclk;
            end
            prev_bclk = bclk;
        end
    end

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    task automatic push(input logic [SW-1:0] s);
        int n;
        n         = 0;
        in_valid  = 1'b1;
        in_sample = s;
        do begin
            step();
            n++;
        end while (!took_last && n < 1000);
        chk("push_accepted", 32'(took_last), 32'd1);
        in_valid  = 1'b0;
        in_sample = SW'($urandom);
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clock);
        #2 reset = 1'b0;

        push(16'hA5C3);
        repeat (300) step();
        push(16'h8001);
        push(16'h7FFE);

        // Present a sample in the load cycle with the buffer empty.
        n = 0;
        while (!((cyc % FRAME_CLK) == LOAD_PH - 1 && pend_q.size() == 0) && n < 1000) begin
            step();
            n++;
        end
        chk("wait_load_cycle", 32'(n < 1000), 32'd1);
        in_valid  = 1'b1;
        in_sample = 16'h1234;
        step();
        in_valid  = 1'b0;

        push(16'hFFFF);
        repeat (3 * FRAME_CLK + 300) step();

        for (int i = 0; i < 25; i++) begin
            repeat ($urandom_range(0, 300)) step();
            push(SW'($urandom));
        end

        n = 0;
        while (!(pend_q.size() == 0 && slot_of(cyc) == 2) && n < 2000) begin
            step();
            n++;
        end
        chk("wait_slot2", 32'(n < 2000), 32'd1);
        push(16'h5555);
        n = 0;
        while (slot_of(cyc) != 20 && n < 2000) begin
            step();
            n++;
        end
        chk("wait_slot20", 32'(n < 2000), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        push(16'h0F0F);
        repeat (700) step();

        chk("frames_checked", 32'(frames >= 20), 32'd1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
